// File: rtl/soc_system_ram_master_pkg.sv
// Shared types and constants for the on-chip RAM fill/verify initiator.
// The macro SOC_SYSTEM_RAM_MASTER_LFSR_EN switches the pattern to an LFSR; LFSR_POLY is its feedback mask.
package soc_system_ram_master_pkg;

  localparam int DEF_ADDR_W    = 10;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_ERR_CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam logic [1:0] MODE_FILL       = 2'b00;
  localparam logic [1:0] MODE_CHECK      = 2'b01;
  localparam logic [1:0] MODE_FILL_CHECK = 2'b10;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

endpackage

// File: rtl/soc_system_ram_master_if.sv
// Avalon-MM link between the fill/verify initiator and the on-chip RAM slave port.
interface soc_system_ram_master_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              chipselect;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              clken;

  modport master (
    output address, byteenable, chipselect, write, writedata, clken,
    input  readdata
  );

  modport slave (
    input  address, byteenable, chipselect, write, writedata, clken,
    output readdata
  );
endinterface

// File: rtl/soc_system_ram_pattern_gen.sv
// Data pattern source: loads a seed, then advances one word per step.
// Incrementing by default; Galois LFSR when SOC_SYSTEM_RAM_MASTER_LFSR_EN is defined.
module soc_system_ram_pattern_gen
  import soc_system_ram_master_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] seed,
  output logic [DATA_W-1:0] data
);

  localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

`ifdef SOC_SYSTEM_RAM_MASTER_LFSR_EN
  localparam logic [DATA_W-1:0] POLY = DATA_W'(LFSR_POLY);

  // An all-zero state would lock the LFSR, so a zero seed is promoted to 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  data <= '0;
    else if (load) data <= (seed == '0) ? ONE : seed;
    else if (step) data <= (data >> 1) ^ (data[0] ? POLY : '0);
  end
`else
  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  data <= '0;
    else if (load) data <= seed;
    else if (step) data <= data + ONE;
  end
`endif

endmodule

// File: rtl/soc_system_ram_master.sv
// Fill/verify engine for the on-chip RAM: writes a pattern over a window, reads it back,
// counts mismatches. Pattern selection follows SOC_SYSTEM_RAM_MASTER_LFSR_EN (see pattern_gen).
module soc_system_ram_master
  import soc_system_ram_master_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ERR_CNT_W = DEF_ERR_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [ADDR_W:0]      length,
  input  logic [DATA_W-1:0]    seed,
  output logic                 busy,
  output logic                 done,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [ADDR_W-1:0]    first_err_addr,
  output logic                 err_valid,
  soc_system_ram_master_if.master avm
);

  localparam int            BE_W    = DATA_W / 8;
  localparam logic [ADDR_W:0] OFS_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [ADDR_W:0]     offset_q, offset_d;
  logic [1:0]          mode_q;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W:0]     len_q;
  logic [DATA_W-1:0]   seed_q;
  logic                accept, rd_load, last_word;
  logic [ADDR_W-1:0]   bus_addr;
  logic [DATA_W-1:0]   wr_data, rd_data, rd_seed;
  logic                cmp_valid_q, mismatch, clken_q;
  logic [DATA_W-1:0]   exp_q;
  logic [ADDR_W-1:0]   cmp_addr_q;

  assign last_word = (offset_q + OFS_ONE) == len_q;
  assign bus_addr  = base_q + offset_q[ADDR_W-1:0];

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    accept   = 1'b0;
    rd_load  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept   = 1'b1;
          rd_load  = 1'b1;
          offset_d = '0;
          if (length == '0 || mode == 2'b11) state_d = ST_DONE;
          else if (mode == MODE_CHECK)       state_d = ST_READ;
          else                               state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (!last_word) begin
          offset_d = offset_q + OFS_ONE;
        end else if (mode_q == MODE_FILL_CHECK) begin
          state_d  = ST_READ;
          offset_d = '0;
          rd_load  = 1'b1;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_READ: begin
        if (last_word) state_d = ST_DRAIN;
        else           offset_d = offset_q + OFS_ONE;
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      offset_q <= '0;
      mode_q   <= '0;
      base_q   <= '0;
      len_q    <= '0;
      seed_q   <= '0;
      clken_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      clken_q  <= 1'b1;
      if (accept) begin
        mode_q <= mode;
        base_q <= base_addr;
        len_q  <= length;
        seed_q <= seed;
      end
    end
  end

  // The expected-data generator restarts from the live seed on a command, or from the
  // captured seed when a fill hands over to its check phase.
  assign rd_seed = (state_q == ST_IDLE) ? seed : seed_q;

  soc_system_ram_pattern_gen #(.DATA_W(DATA_W)) u_wr_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (accept),
    .step    (state_q == ST_WRITE),
    .seed    (seed),
    .data    (wr_data)
  );

  soc_system_ram_pattern_gen #(.DATA_W(DATA_W)) u_rd_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (rd_load),
    .step    (state_q == ST_READ),
    .seed    (rd_seed),
    .data    (rd_data)
  );

  // Read data returns one cycle after the access, so expectation and address ride one stage behind.
  assign mismatch = cmp_valid_q && (avm.readdata != exp_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmp_valid_q    <= 1'b0;
      exp_q          <= '0;
      cmp_addr_q     <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
      err_valid      <= 1'b0;
    end else begin
      cmp_valid_q <= (state_q == ST_READ);
      exp_q       <= rd_data;
      cmp_addr_q  <= bus_addr;
      if (accept) begin
        err_count      <= '0;
        first_err_addr <= '0;
        err_valid      <= 1'b0;
      end else if (mismatch) begin
        if (err_count != '1) err_count <= err_count + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
        if (!err_valid) begin
          first_err_addr <= cmp_addr_q;
          err_valid      <= 1'b1;
        end
      end
    end
  end

  // Bus outputs decode straight from state so an async reset idles the bus at once.
  assign avm.chipselect = (state_q == ST_WRITE) || (state_q == ST_READ);
  assign avm.write      = (state_q == ST_WRITE);
  assign avm.byteenable = {BE_W{avm.chipselect}};
  assign avm.address    = avm.chipselect ? bus_addr : '0;
  assign avm.writedata  = avm.write ? wr_data : '0;
  assign avm.clken      = clken_q;

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);

endmodule

// File: doc/soc_system_ram_master.md
Name: soc_system_ram_master

Overview:
Avalon-MM initiator that drives the on-chip RAM slave port: address, byteenable, chipselect, write, writedata and clken out; readdata in. It is a fill/verify engine:
- Writes a generated data pattern over a RAM window.
- Reads the window back and compares each word against the same pattern.
- Reports an error count and the first failing address.
It sits between the HPS-side control registers and the RAM, for memory bring-up and BIST.

Parameters:
ADDR_W, 10, RAM word-address width; window wraps modulo 2^ADDR_W
DATA_W, 32, RAM data width; byteenable width = DATA_W/8
ERR_CNT_W, 16, width of the saturating error counter

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle command strobe, sampled in IDLE only
mode  in  2  00 fill, 01 check, 10 fill-then-check, 11 reserved (treated as no-op)
base_addr  in  ADDR_W  first word address
length  in  ADDR_W+1  word count, 0..2^ADDR_W
seed  in  DATA_W  pattern seed
busy  out  1  high from the first bus cycle through the DONE cycle
done  out  1  one-cycle pulse at completion
err_count  out  ERR_CNT_W  mismatch count, saturating
first_err_addr  out  ADDR_W  address of the first mismatch
err_valid  out  1  high once first_err_addr holds a captured value
avm_address  out  ADDR_W  RAM address
avm_byteenable  out  DATA_W/8  always all-ones while chipselect is high, else 0
avm_chipselect  out  1  bus access qualifier
avm_write  out  1  write strobe
avm_writedata  out  DATA_W  write data
avm_readdata  in  DATA_W  read data, valid exactly 1 cycle after a read access
avm_clken  out  1  RAM clock enable; 1 whenever out of reset

Behaviour:
- Reset values: all outputs 0, state IDLE.
- Async reset assertion takes effect mid-operation: the bus is idled immediately and no done pulse is produced.
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE transitions:
  - start=1 with length=0 or mode=11: go to DONE (no bus traffic, error outputs cleared).
  - start=1 with mode 00 or 10: go to WRITE.
  - start=1 with mode 01: go to READ.
  - On any accepted start: clear err_count, err_valid and first_err_addr; load the offset counter with 0.
- start is ignored in every state other than IDLE.
- WRITE:
  - One write per cycle: chipselect=1, write=1, address = (base_addr + offset) mod 2^ADDR_W, writedata = pattern(offset).
  - After length words: mode 10 goes to READ with offset reset to 0; otherwise go to DONE.
- READ:
  - One read per cycle: chipselect=1, write=0, same address rule.
  - Expected data and address are delayed one stage.
  - Each cycle, readdata is compared against the previous cycle's expected value.
  - After length reads, go to DRAIN.
- DRAIN: bus idle; the last word is compared; then go to DONE.
- DONE: done=1 and busy=1 for one cycle, then IDLE.
- Timing, with start sampled in cycle 0 and length = N:
  - fill: writes in cycles 1..N, done in cycle N+1.
  - check: reads in cycles 1..N, done in cycle N+2.
  - fill-then-check: done in cycle 2N+2.
- Pattern (default): pattern(k) = (seed + k) mod 2^DATA_W.
- Mismatch handling:
  - err_count increments by 1, saturating at all-ones.
  - The first mismatch latches first_err_addr and sets err_valid.
  - Later mismatches do not overwrite first_err_addr.
- Address wrap: base_addr + offset wraps past 2^ADDR_W-1 to 0. length = 2^ADDR_W covers the whole RAM exactly once.

Optional Feature:
SOC_SYSTEM_RAM_MASTER_LFSR_EN
- Defined: pattern(0) = seed (seed 0 is replaced by 1). Each later word advances a DATA_W-bit Galois LFSR one step, polynomial 0x80200003. The write side and the expected-data side use identical generators, both restarted at the start of each phase.
- Undefined: incrementing pattern as described in Behaviour. No LFSR logic is synthesised.

Decomposition:
- Package soc_system_ram_master_pkg holds:
  - the state enum;
  - mode codes MODE_FILL, MODE_CHECK, MODE_FILL_CHECK;
  - LFSR_POLY;
  - the default widths.
- One sub-module, soc_system_ram_pattern_gen: seed load, step enable, DATA_W output, incrementing or LFSR per the macro. It is instantiated twice, once for write data and once for expected data.

Test Plan:
- Fill: mode=00, base=0x010, length=4, seed=0xA5A50000 -> writes to 0x010..0x013 with data A5A50000..A5A50003, byteenable=F; done in cycle 5; err_count=0.
- Check with fault: preload RAM model as above but word 0x012 = 0xDEADBEEF; mode=01 -> err_count=1, first_err_addr=0x012, err_valid=1, done in cycle 6.
- Wrap and fill-then-check: base=0x3FE, length=4, mode=10 -> addresses 0x3FE, 0x3FF, 0x000, 0x001 written then read; err_count=0; done in cycle 10.
- Degenerate commands: length=0 or mode=11 -> no chipselect; done pulse in cycle 1.
- Start while busy: a second start during WRITE is ignored.
- Reset mid-operation: reset_n low during READ -> chipselect, write and busy drop to 0 immediately; no done pulse.
- Saturation: ERR_CNT_W=2 with 6 forced mismatches -> err_count=3; first_err_addr = first failing address.
